// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - program store and instruction responder for the 8-bit MIPS core
//
// Load mode: each debounced press of Load_Strobe appends Load_Data to the
// program RAM while the core is held in reset. Run mode: the RAM answers the
// core's PC with a registered Instruction byte.
//
// Ports:
//   Clk_O        board clock, all state on rising edge
//   Reset        asynchronous, active-high reset
//   Load_Mode    raw switch, 1 = load, 0 = run (asynchronous)
//   Load_Strobe  raw bouncy push-button (asynchronous)
//   Load_Data    instruction byte from switches
//   PC           core program counter
//   Instruction  registered instruction byte to core
//   CPU_Hold     1 = hold the core in reset
//   Count        number of words loaded
//   Full         registered, Count == DEPTH
//   Wr_Pulse     one-cycle pulse on each accepted write

module imem_loader #(
  parameter int         DEPTH     = 16,
  parameter int         DB_CYCLES = 4,
  parameter logic [7:0] FILL      = 8'h00
) (
  input  logic       Clk_O,
  input  logic       Reset,
  input  logic       Load_Mode,
  input  logic       Load_Strobe,
  input  logic [7:0] Load_Data,
  input  logic [7:0] PC,
  output logic [7:0] Instruction,
  output logic       CPU_Hold,
  output logic [7:0] Count,
  output logic       Full,
  output logic       Wr_Pulse
);

  localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              DBW     = $clog2(DB_CYCLES + 1);
  localparam logic [DBW-1:0]  DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [7:0]      DEPTH_B = 8'(DEPTH);

  typedef enum logic {S_LOAD, S_RUN} state_t;

  state_t         r_state, w_state_next;
  logic           r_m0, r_m1, r_s0, r_s1;
  logic           r_d, r_d_q;
  logic [DBW-1:0] r_db_cnt;
  logic [7:0]     r_instr, r_count;
  logic           r_full, r_wr_pulse;
  logic [7:0]     r_mem [DEPTH];

  logic           w_press;
  logic           w_wr_en;
  logic [7:0]     w_count_next, w_instr_next, w_rd_data;
  logic           w_full_next;

  // Two-flop synchronizers and strobe debouncer. The counter only runs while
  // the synchronized level disagrees with the debounced level, so any
  // excursion shorter than DB_CYCLES is forgotten as soon as it ends.
  always_ff @(posedge Clk_O or posedge Reset) begin
    if (Reset) begin
      r_m0     <= 1'b0;
      r_m1     <= 1'b0;
      r_s0     <= 1'b0;
      r_s1     <= 1'b0;
      r_d      <= 1'b0;
      r_d_q    <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_m0  <= Load_Mode;
      r_m1  <= r_m0;
      r_s0  <= Load_Strobe;
      r_s1  <= r_s0;
      r_d_q <= r_d;
      if (r_s1 == r_d) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_d      <= r_s1;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  assign w_press   = r_d & ~r_d_q;
  assign w_rd_data = r_mem[PC[AW-1:0]];

  always_comb begin
    w_state_next = r_state;
    w_wr_en      = 1'b0;
    w_count_next = r_count;
    w_full_next  = r_full;
    w_instr_next = FILL;
    case (r_state)
      S_LOAD: begin
        // A press coinciding with the switch to run still lands in the RAM.
        if (w_press && (r_count < DEPTH_B)) begin
          w_wr_en      = 1'b1;
          w_count_next = r_count + 8'd1;
          w_full_next  = ((r_count + 8'd1) == DEPTH_B);
        end
        if (!r_m1) w_state_next = S_RUN;
      end
      S_RUN: begin
        // Count never exceeds DEPTH, so this also blocks PCs beyond the RAM.
        w_instr_next = (PC < r_count) ? w_rd_data : FILL;
        if (r_m1) begin
          w_state_next = S_LOAD;
          w_count_next = 8'd0;
          w_full_next  = 1'b0;
          w_instr_next = FILL;
        end
      end
      default: w_state_next = S_LOAD;
    endcase
  end

  always_ff @(posedge Clk_O or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_LOAD;
      r_instr    <= FILL;
      r_count    <= 8'd0;
      r_full     <= 1'b0;
      r_wr_pulse <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_instr    <= w_instr_next;
      r_count    <= w_count_next;
      r_full     <= w_full_next;
      r_wr_pulse <= w_wr_en;
    end
  end

  // Program RAM has no reset so its contents survive Reset and mode changes.
  always_ff @(posedge Clk_O) begin
    if (w_wr_en) r_mem[r_count[AW-1:0]] <= Load_Data;
  end

  assign Instruction = r_instr;
  assign CPU_Hold    = (r_state == S_LOAD);
  assign Count       = r_count;
  assign Full        = r_full;
  assign Wr_Pulse    = r_wr_pulse;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader with a reference program-store model

module tb_imem_loader;

  localparam int         DEPTH = 16;
  localparam int         DB    = 4;
  localparam logic [7:0] FILL  = 8'h00;

  localparam int K_INSTR = 0;
  localparam int K_HOLD  = 1;
  localparam int K_COUNT = 2;
  localparam int K_FULL  = 3;

  logic       Clk_O = 1'b0;
  logic       Reset = 1'b0;
  logic       Load_Mode = 1'b1;
  logic       Load_Strobe = 1'b0;
  logic [7:0] Load_Data = 8'h00;
  logic [7:0] PC = 8'h00;
  logic [7:0] Instruction;
  logic       CPU_Hold;
  logic [7:0] Count;
  logic       Full;
  logic       Wr_Pulse;

  imem_loader #(.DEPTH(DEPTH), .DB_CYCLES(DB), .FILL(FILL)) dut (
    .Clk_O       (Clk_O),
    .Reset       (Reset),
    .Load_Mode   (Load_Mode),
    .Load_Strobe (Load_Strobe),
    .Load_Data   (Load_Data),
    .PC          (PC),
    .Instruction (Instruction),
    .CPU_Hold    (CPU_Hold),
    .Count       (Count),
    .Full        (Full),
    .Wr_Pulse    (Wr_Pulse)
  );

  always #5 Clk_O = ~Clk_O;

  // cyc == k at the falling edge that follows rising edge number k
  int cyc = 0;
  always @(posedge Clk_O) cyc <= cyc + 1;

  int nchk = 0;
  int nerr = 0;

  // Reference model: what has been loaded since the last entry to load mode.
  logic [7:0] mdl_mem [DEPTH];
  int         mdl_count = 0;
  bit         mdl_load  = 1'b1;

  typedef struct { int cyc; int kind; int val; } exp_t;
  typedef struct { int cyc; int cnt; } pulse_t;
  exp_t   eq[$];
  pulse_t pq[$];

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic string kname(input int k);
    case (k)
      K_INSTR: return "instruction";
      K_HOLD:  return "cpu_hold";
      K_COUNT: return "count";
      default: return "full";
    endcase
  endfunction

  // Monitor: compares timed expectations and every Wr_Pulse against the queues.
  always @(negedge Clk_O) begin
    int     act;
    pulse_t p;
    if (!Reset) begin
      for (int i = eq.size() - 1; i >= 0; i--) begin
        if (eq[i].cyc <= cyc) begin
          case (eq[i].kind)
            K_INSTR: act = int'(Instruction);
            K_HOLD:  act = int'(CPU_Hold);
            K_COUNT: act = int'(Count);
            default: act = int'(Full);
          endcase
          check(kname(eq[i].kind), act, eq[i].val);
          eq.delete(i);
        end
      end
      if (Wr_Pulse) begin
        if (pq.size() == 0) begin
          check("unexpected_wr_pulse", 1, 0);
        end else begin
          p = pq.pop_front();
          check("wr_pulse_cycle", cyc, p.cyc);
          check("wr_count", int'(Count), p.cnt);
          check("wr_full", int'(Full), (p.cnt == DEPTH) ? 1 : 0);
        end
      end else if (pq.size() > 0 && pq[0].cyc < cyc) begin
        check("missed_wr_pulse", 0, 1);
        p = pq.pop_front();
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clk_O);
  endtask

  task automatic push_exp(input int c, input int k, input int v);
    exp_t e;
    e.cyc = c; e.kind = k; e.val = v;
    eq.push_back(e);
  endtask

  task automatic press(input logic [7:0] data, input bit bounce);
    pulse_t p;
    int     k;
    @(negedge Clk_O);
    Load_Data = data;
    if (bounce) begin
      Load_Strobe = 1'b1; tick(2);
      Load_Strobe = 1'b0; tick(2);
    end
    Load_Strobe = 1'b1;
    k = cyc;
    if (mdl_load && mdl_count < DEPTH) begin
      mdl_mem[mdl_count] = data;
      mdl_count++;
      p.cyc = k + 1 + 2 + DB;
      p.cnt = mdl_count;
      pq.push_back(p);
    end
    tick(10);
    Load_Strobe = 1'b0;
    tick(12);
  endtask

  task automatic glitch(input int len);
    @(negedge Clk_O);
    Load_Strobe = 1'b1;
    tick(len);
    Load_Strobe = 1'b0;
    tick(8);
  endtask

  task automatic set_mode(input bit load);
    int k;
    @(negedge Clk_O);
    k = cyc;
    Load_Mode = load;
    if (!load) begin
      push_exp(k + 2, K_HOLD, 1);
      push_exp(k + 3, K_HOLD, 0);
      push_exp(k + 3, K_INSTR, FILL);
      mdl_load = 1'b0;
    end else begin
      push_exp(k + 2, K_HOLD, 0);
      push_exp(k + 3, K_HOLD, 1);
      push_exp(k + 3, K_COUNT, 0);
      push_exp(k + 3, K_FULL, 0);
      push_exp(k + 3, K_INSTR, FILL);
      mdl_load  = 1'b1;
      mdl_count = 0;
    end
    tick(5);
  endtask

  task automatic read(input int p);
    int exp;
    @(negedge Clk_O);
    PC = 8'(p);
    exp = (p < mdl_count) ? int'(mdl_mem[p]) : int'(FILL);
    push_exp(cyc + 1, K_INSTR, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] first_word;

    // Reset state
    #1 Reset = 1'b1;
    tick(3);
    check("rst_instruction", int'(Instruction), FILL);
    check("rst_cpu_hold", int'(CPU_Hold), 1);
    check("rst_count", int'(Count), 0);
    check("rst_full", int'(Full), 0);
    check("rst_wr_pulse", int'(Wr_Pulse), 0);
    @(negedge Clk_O);
    Reset = 1'b0;
    tick(6);
    check("load_cpu_hold", int'(CPU_Hold), 1);
    check("load_count", int'(Count), 0);
    check("load_instruction", int'(Instruction), FILL);

    // Three clean presses
    press(8'h41, 1'b0);
    press(8'h86, 1'b0);
    press(8'hC3, 1'b0);
    check("count_after_three", int'(Count), 3);

    // Run mode reads
    set_mode(1'b0);
    read(1);
    read(3);
    read(200);
    read(0);
    read(2);
    for (int i = 0; i < 20; i++) read(($urandom_range(0, 1) == 1) ? $urandom_range(0, 255) : $urandom_range(0, 4));
    tick(3);

    // Back to load: count cleared; glitches and bounce before a held press
    set_mode(1'b1);
    for (int i = 0; i < 3; i++) glitch($urandom_range(1, DB - 1));
    first_word = 8'($urandom);
    press(first_word, 1'b1);
    check("count_after_bounce", int'(Count), 1);

    // Fill to DEPTH and one extra press
    for (int i = 0; i < DEPTH; i++) press(8'($urandom), 1'b0);
    check("count_full", int'(Count), DEPTH);
    check("full_flag", int'(Full), 1);

    set_mode(1'b0);
    read(0);
    check("first_word_model", int'(mdl_mem[0]), int'(first_word));
    for (int i = 0; i < 30; i++) read(($urandom_range(0, 1) == 1) ? $urandom_range(0, 255) : $urandom_range(0, DEPTH - 1));
    tick(3);

    // Reset in the middle of a press's debounce
    set_mode(1'b1);
    press(8'h55, 1'b0);
    @(negedge Clk_O);
    Load_Data   = 8'($urandom);
    Load_Strobe = 1'b1;
    tick(3);
    Reset       = 1'b1;
    Load_Strobe = 1'b0;
    Load_Mode   = 1'b0;
    mdl_count   = 0;
    mdl_load    = 1'b0;
    tick(3);
    check("midreset_count", int'(Count), 0);
    check("midreset_hold", int'(CPU_Hold), 1);
    check("midreset_wr_pulse", int'(Wr_Pulse), 0);
    @(negedge Clk_O);
    Reset = 1'b0;
    tick(4);
    check("after_reset_run_hold", int'(CPU_Hold), 0);
    check("after_reset_count", int'(Count), 0);
    read(0);
    read(1);
    for (int i = 0; i < 10; i++) read($urandom_range(0, 255));
    tick(12);

    check("pulse_queue_drained", pq.size(), 0);
    check("exp_queue_drained", eq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program store and instruction responder for the 8-bit MIPS core. In load mode it captures instruction bytes entered on board switches, one per debounced button press, into an internal program RAM while holding the core in reset. In run mode it answers the core's `PC` with the stored `Instruction` byte. It replaces the hand-fed switch instruction input at the top level.

## Interface

Parameters:
- `DEPTH`, 16: program RAM words, 1..255; address width `AW = clog2(DEPTH)` (minimum 1).
- `DB_CYCLES`, 4: consecutive `Clk_O` cycles a synchronized strobe level must persist before it is accepted; ≥1.
- `FILL`, 8'h00: byte returned for unloaded addresses and while loading.

Ports:
- `Clk_O` input 1: board clock; all state on rising edge.
- `Reset` input 1: reset, asynchronous, active-high.
- `Load_Mode` input 1: raw switch; 1 = load, 0 = run; asynchronous to `Clk_O`.
- `Load_Strobe` input 1: raw push-button; bouncy, asynchronous.
- `Load_Data` input 8: instruction byte from switches.
- `PC` input 8: core program counter.
- `Instruction` output 8: registered instruction byte to core.
- `CPU_Hold` output 1: 1 = hold the core in reset; OR it into the core `Reset`.
- `Count` output 8: number of words loaded.
- `Full` output 1: `Count == DEPTH`.
- `Wr_Pulse` output 1: one-cycle pulse on each accepted write.

## Operation

- Synchronizers: `Load_Mode` and `Load_Strobe` each pass through two flops (m0→m1, s0→s1) that reset to 0.
- Debounce: debounced level `d` (reset 0) and counter `db_cnt` (reset 0).
  - When `s1 == d`, `db_cnt` is cleared to 0.
  - Otherwise `db_cnt` increments. On the edge where it would reach `DB_CYCLES`, `d <= s1` and `db_cnt <= 0`.
- Accepted press: `press = d & ~d_q`, where `d_q` is `d` delayed one cycle. Only rising edges of `d` are used.
- FSM states:
  - S_LOAD: reset state. `CPU_Hold = 1`, `Instruction <= FILL`.
    - On `press` with `Count < DEPTH`: `mem[Count] <= Load_Data`, `Count <= Count+1`, `Wr_Pulse = 1`.
    - On `press` with `Count == DEPTH`: no write, no pulse.
    - `m1 == 0` → S_RUN.
  - S_RUN: `CPU_Hold = 0`. Every edge, `Instruction <= (PC < Count) ? mem[PC[AW-1:0]] : FILL`.
    - `press` is ignored.
    - `m1 == 1` → S_LOAD. On that same edge: `Count <= 0`, `Full <= 0`, `CPU_Hold <= 1`, `Instruction <= FILL`.
- RAM contents are not reset and survive mode changes. Reloading overwrites from address 0.
- `PC` values ≥ `DEPTH` always return `FILL`, because `Count ≤ DEPTH`.

## Timing

- Reset values: `Instruction = FILL`, `CPU_Hold = 1`, `Count = 0`, `Full = 0`, `Wr_Pulse = 0`, state S_LOAD, all sync/debounce flops 0.
- Write latency: `Load_Strobe` first sampled high at edge E and held stable → `d` rises at E+1+`DB_CYCLES` → the RAM write, `Count` increment and `Wr_Pulse` assertion all take effect at E+2+`DB_CYCLES`. With `DB_CYCLES=4` this is edge E+6.
- A high glitch, or a low gap during a held press, shorter than `DB_CYCLES` synchronized cycles is rejected.
- Mode latency: `Load_Mode` change first sampled at edge E → state changes at edge E+2.
- Read latency in S_RUN: `Instruction` reflects the `PC` sampled one edge earlier, so one `Clk_O` cycle. This is negligible against the divided core clock.
- `Full` is registered. It updates on the same edge as `Count` (`Full` = 1 when `Count` becomes `DEPTH`).
- Simultaneous `press` and S_LOAD→S_RUN on one edge: the write completes and `Count` includes it. The first S_RUN read is on the next edge.
- Reset mid-load or mid-run: immediate return to reset values. A partially debounced press is discarded. RAM is untouched.

## Test plan

1. Assert `Reset`, then release with `Load_Mode=1` → `Instruction=8'h00`, `CPU_Hold=1`, `Count=0`, `Full=0`, no `Wr_Pulse`.
2. With `DB_CYCLES=4`, press (hold 10 cycles) with `Load_Data` 8'h41, then 8'h86, then 8'hC3 → `Wr_Pulse` at exactly E+6 after each press's first sampled-high edge; `Count=3`.
3. Strobe glitch high for 3 cycles, then bounce 1-0-1 with each level held 2 cycles before a held press → the glitch and bounce cause no write; the held press causes exactly one write.
4. `DEPTH=16`: 17 presses → `Full=1` and `Count=16` after the 16th; the 17th press gives no `Wr_Pulse` and `mem[0]` is unchanged.
5. After test 2, set `Load_Mode=0` → `CPU_Hold` falls 2 edges later. Then `PC=1` → `Instruction=8'h86` one edge later; `PC=3` → 8'h00; `PC=200` → 8'h00.
6. In S_RUN, set `Load_Mode=1` → `Count=0`, `CPU_Hold=1`, `Instruction=FILL`. Load one word 8'h55, assert `Reset` during a second press's debounce, then release and run → `Count=0`, all reads return FILL, and `mem[0]=8'h55` is retained.
